// File: rtl/programador_tiempo.sv
// programador_tiempo: BCD mm:ss time editor (IDLE/EDIT/LISTO) driven by edge-detected buttons.
// Define PROGRAMADOR_AUTOREPEAT_EN to add hold-to-repeat on btn_up/btn_down.
module programador_tiempo #(
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_PERIOD = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_sel,
    input  logic        btn_ok,
    output logic [11:0] tiempo_establecido,
    output logic [1:0]  digito_sel,
    output logic        editando,
    output logic        cargar,
    output logic [1:0]  estado_dbg_o
);

    // Encoding is visible on estado_dbg_o: 0=IDLE, 1=EDIT, 2=LISTO.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EDIT  = 2'd1,
        LISTO = 2'd2
    } estado_t;

    estado_t     estado_q;
    logic [11:0] tiempo_q;
    logic [1:0]  sel_q;
    logic        editando_q;
    logic        cargar_q;
    logic        up_prev_q;
    logic        down_prev_q;
    logic        sel_prev_q;
    logic        ok_prev_q;

    logic        up_edge;
    logic        down_edge;
    logic        sel_edge;
    logic        ok_edge;
    logic        paso_up;
    logic        paso_down;
    logic [3:0]  digito_act;
    logic [3:0]  digito_max;
    logic [3:0]  digito_inc;
    logic [3:0]  digito_dec;
    logic [3:0]  digito_nuevo;
    logic [11:0] tiempo_paso;

    assign up_edge   = btn_up & ~up_prev_q;
    assign down_edge = btn_down & ~down_prev_q;
    assign sel_edge  = btn_sel & ~sel_prev_q;
    assign ok_edge   = btn_ok & ~ok_prev_q;

`ifdef PROGRAMADOR_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CW      = $clog2(RPT_MAX + 1);
    localparam logic [CW-1:0] DELAY_C  = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] PERIOD_C = CW'(REPEAT_PERIOD);

    logic [CW-1:0] rpt_cnt_q;
    logic [CW-1:0] rpt_cnt_d;
    logic [CW-1:0] rpt_cnt_mas;
    logic          rpt_on_q;
    logic          rpt_on_d;
    logic          up_sosten;
    logic          down_sosten;
    logic          rpt_activo;
    logic          rpt_paso;

    // A hold only counts while exactly one of up/down stays high past its edge.
    assign up_sosten   = btn_up & up_prev_q & ~btn_down;
    assign down_sosten = btn_down & down_prev_q & ~btn_up;
    assign rpt_activo  = (estado_q == EDIT) & (up_sosten | down_sosten);
    assign rpt_cnt_mas = rpt_cnt_q + CW'(1);

    always_comb begin
        rpt_paso  = 1'b0;
        rpt_cnt_d = '0;
        rpt_on_d  = 1'b0;
        if (rpt_activo) begin
            rpt_on_d  = rpt_on_q;
            rpt_cnt_d = rpt_cnt_mas;
            if (rpt_cnt_mas == (rpt_on_q ? PERIOD_C : DELAY_C)) begin
                rpt_paso  = 1'b1;
                rpt_cnt_d = '0;
                rpt_on_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rpt_cnt_q <= '0;
            rpt_on_q  <= 1'b0;
        end else begin
            rpt_cnt_q <= rpt_cnt_d;
            rpt_on_q  <= rpt_on_d;
        end
    end

    assign paso_up   = (up_edge & ~down_edge) | (rpt_paso & up_sosten);
    assign paso_down = (down_edge & ~up_edge) | (rpt_paso & down_sosten);
`else
    assign paso_up   = up_edge & ~down_edge;
    assign paso_down = down_edge & ~up_edge;
`endif

    // Each digit wraps inside its own range; no carry or borrow between digits.
    always_comb begin
        case (sel_q)
            2'd2:    digito_act = tiempo_q[11:8];
            2'd1:    digito_act = tiempo_q[7:4];
            default: digito_act = tiempo_q[3:0];
        endcase
        digito_max   = (sel_q == 2'd1) ? 4'd5 : 4'd9;
        digito_inc   = (digito_act >= digito_max) ? 4'd0 : digito_act + 4'd1;
        digito_dec   = (digito_act == 4'd0) ? digito_max : digito_act - 4'd1;
        digito_nuevo = paso_up ? digito_inc : digito_dec;
        tiempo_paso  = tiempo_q;
        case (sel_q)
            2'd2:    tiempo_paso[11:8] = digito_nuevo;
            2'd1:    tiempo_paso[7:4]  = digito_nuevo;
            default: tiempo_paso[3:0]  = digito_nuevo;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q    <= IDLE;
            tiempo_q    <= 12'h000;
            sel_q       <= 2'd0;
            editando_q  <= 1'b0;
            cargar_q    <= 1'b0;
            up_prev_q   <= 1'b0;
            down_prev_q <= 1'b0;
            sel_prev_q  <= 1'b0;
            ok_prev_q   <= 1'b0;
        end else begin
            up_prev_q   <= btn_up;
            down_prev_q <= btn_down;
            sel_prev_q  <= btn_sel;
            ok_prev_q   <= btn_ok;
            cargar_q    <= 1'b0;
            case (estado_q)
                IDLE: begin
                    if (sel_edge) begin
                        estado_q   <= EDIT;
                        sel_q      <= 2'd2;
                        editando_q <= 1'b1;
                    end
                end
                EDIT: begin
                    // ok wins the cycle even when it is refused for a zero time.
                    if (ok_edge) begin
                        if (tiempo_q != 12'h000) begin
                            estado_q   <= LISTO;
                            editando_q <= 1'b0;
                            cargar_q   <= 1'b1;
                        end
                    end else if (sel_edge) begin
                        sel_q <= (sel_q == 2'd0) ? 2'd2 : sel_q - 2'd1;
                    end else if (paso_up || paso_down) begin
                        tiempo_q <= tiempo_paso;
                    end
                end
                LISTO: begin
                    if (sel_edge) begin
                        estado_q   <= EDIT;
                        sel_q      <= 2'd2;
                        editando_q <= 1'b1;
                    end
                end
                default: begin
                    estado_q   <= IDLE;
                    editando_q <= 1'b0;
                end
            endcase
        end
    end

    assign tiempo_establecido = tiempo_q;
    assign digito_sel         = sel_q;
    assign editando           = editando_q;
    assign cargar             = cargar_q;
    assign estado_dbg_o       = estado_q;

endmodule

// File: tb/tb_programador_tiempo.sv
// tb_programador_tiempo: directed scenarios plus random button traffic against a digit-array model.
// Works with or without PROGRAMADOR_AUTOREPEAT_EN defined.
module tb_programador_tiempo;

    localparam int DLY     = 4;
    localparam int PER     = 2;
    localparam int M_IDLE  = 0;
    localparam int M_EDIT  = 1;
    localparam int M_LISTO = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        btn_up = 1'b0;
    logic        btn_down = 1'b0;
    logic        btn_sel = 1'b0;
    logic        btn_ok = 1'b0;
    logic [11:0] tiempo_establecido;
    logic [1:0]  digito_sel;
    logic        editando;
    logic        cargar;
    logic [1:0]  estado_dbg_o;

    programador_tiempo #(
        .REPEAT_DELAY (DLY),
        .REPEAT_PERIOD(PER)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .btn_up            (btn_up),
        .btn_down          (btn_down),
        .btn_sel           (btn_sel),
        .btn_ok            (btn_ok),
        .tiempo_establecido(tiempo_establecido),
        .digito_sel        (digito_sel),
        .editando          (editando),
        .cargar            (cargar),
        .estado_dbg_o      (estado_dbg_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: digits as plain integers, index 2=minutes, 1=tens, 0=units.
    int m_st;
    int m_sel;
    int m_hold;
    int m_d[3];
    bit m_cargar;
    bit m_pu, m_pd, m_ps, m_po;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_tiempo();
        return 16'((m_d[2] << 8) | (m_d[1] << 4) | m_d[0]);
    endfunction

    function automatic int rango(input int idx);
        return (idx == 1) ? 6 : 10;
    endfunction

    task automatic model_reset();
        m_st = M_IDLE;
        m_sel = 0;
        m_hold = 0;
        for (int i = 0; i < 3; i++) m_d[i] = 0;
        m_cargar = 1'b0;
        m_pu = 1'b0; m_pd = 1'b0; m_ps = 1'b0; m_po = 1'b0;
    endtask

    task automatic model_clock(input bit u, input bit dn, input bit s, input bit o);
        bit eu, ed, es, eo, rpt, held, nc;
        eu = u && !m_pu;
        ed = dn && !m_pd;
        es = s && !m_ps;
        eo = o && !m_po;
        rpt = 1'b0;
        nc = 1'b0;
`ifdef PROGRAMADOR_AUTOREPEAT_EN
        held = (m_st == M_EDIT) && ((u && m_pu && !dn) || (dn && m_pd && !u));
        if (held) begin
            m_hold++;
            rpt = (m_hold == DLY) || (m_hold > DLY && ((m_hold - DLY) % PER) == 0);
        end else begin
            m_hold = 0;
        end
`else
        held = 1'b0;
`endif
        case (m_st)
            M_IDLE: if (es) begin m_st = M_EDIT; m_sel = 2; end
            M_EDIT: begin
                if (eo) begin
                    if (m_tiempo() != 0) begin m_st = M_LISTO; nc = 1'b1; end
                end else if (es) begin
                    m_sel = (m_sel == 0) ? 2 : m_sel - 1;
                end else if ((eu && !ed) || (rpt && u)) begin
                    m_d[m_sel] = (m_d[m_sel] + 1) % rango(m_sel);
                end else if ((ed && !eu) || (rpt && dn)) begin
                    m_d[m_sel] = (m_d[m_sel] + rango(m_sel) - 1) % rango(m_sel);
                end
            end
            default: if (es) begin m_st = M_EDIT; m_sel = 2; end
        endcase
        m_cargar = nc;
        m_pu = u; m_pd = dn; m_ps = s; m_po = o;
    endtask

    task automatic step(input bit u, input bit dn, input bit s, input bit o, input bit r);
        @(negedge clk);
        btn_up = u; btn_down = dn; btn_sel = s; btn_ok = o; reset = r;
        @(posedge clk);
        if (r) model_reset();
        else model_clock(u, dn, s, o);
        #1;
        check_eq("tiempo", 16'(tiempo_establecido), m_tiempo());
        check_eq("digito_sel", 16'(digito_sel), 16'(m_sel));
        check_eq("editando", 16'(editando), 16'(m_st == M_EDIT));
        check_eq("cargar", 16'(cargar), 16'(m_cargar));
        check_eq("estado", 16'(estado_dbg_o), 16'(m_st));
    endtask

    task automatic press(input bit u, input bit dn, input bit s, input bit o);
        step(u, dn, s, o, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit u, dn, s, o;
        model_reset();

        // Reset values
        do_reset();
        check_eq("rst_tiempo", 16'(tiempo_establecido), 16'h000);
        check_eq("rst_sel", 16'(digito_sel), 16'd0);
        check_eq("rst_editando", 16'(editando), 16'd0);
        check_eq("rst_cargar", 16'(cargar), 16'd0);

        // sel, up x3, ok -> 3:00 loaded
        press(0, 0, 1, 0);
        repeat (3) press(1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        check_eq("r026_cargar", 16'(cargar), 16'd1);
        check_eq("r026_estado", 16'(estado_dbg_o), 16'(M_LISTO));
        check_eq("r026_tiempo", 16'(tiempo_establecido), 16'h300);
        check_eq("r026_sel", 16'(digito_sel), 16'd2);
        step(0, 0, 0, 0, 0);
        check_eq("r026_cargar_off", 16'(cargar), 16'd0);

        // Digit wrap with no carry/borrow
        press(0, 0, 1, 0);
        press(0, 0, 1, 0);
        press(0, 1, 0, 0);
        check_eq("r027_tens_down", 16'(tiempo_establecido), 16'h350);
        press(1, 0, 0, 0);
        check_eq("r027_tens_up", 16'(tiempo_establecido), 16'h300);
        press(0, 0, 1, 0);
        press(0, 1, 0, 0);
        check_eq("r027_units_down", 16'(tiempo_establecido), 16'h309);

        // ok refused at zero, accepted at 0:01
        do_reset();
        press(0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        check_eq("r028_stay_edit", 16'(estado_dbg_o), 16'(M_EDIT));
        check_eq("r028_no_cargar", 16'(cargar), 16'd0);
        step(0, 0, 0, 0, 0);
        press(0, 0, 1, 0);
        press(0, 0, 1, 0);
        press(1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        check_eq("r028_tiempo", 16'(tiempo_establecido), 16'h001);
        check_eq("r028_estado", 16'(estado_dbg_o), 16'(M_LISTO));
        check_eq("r028_cargar", 16'(cargar), 16'd1);
        step(0, 0, 0, 0, 0);

        // Simultaneous edges
        do_reset();
        press(0, 0, 1, 0);
        press(1, 0, 0, 0);
        press(0, 0, 1, 0);
        press(1, 0, 0, 0);
        press(1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        check_eq("r029_updown", 16'(tiempo_establecido), 16'h120);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0);
        check_eq("r029_ok_up_tiempo", 16'(tiempo_establecido), 16'h120);
        check_eq("r029_ok_up_estado", 16'(estado_dbg_o), 16'(M_LISTO));
        step(0, 0, 0, 0, 0);

        // Reset from LISTO during the cargar pulse, then up ignored in IDLE
        do_reset();
        press(0, 0, 1, 0);
        repeat (2) press(1, 0, 0, 0);
        press(0, 0, 1, 0);
        repeat (4) press(1, 0, 0, 0);
        press(0, 0, 1, 0);
        repeat (5) press(1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        check_eq("r030_loaded", 16'(tiempo_establecido), 16'h245);
        do_reset();
        check_eq("r030_estado", 16'(estado_dbg_o), 16'(M_IDLE));
        check_eq("r030_tiempo", 16'(tiempo_establecido), 16'h000);
        check_eq("r030_editando", 16'(editando), 16'd0);
        check_eq("r030_cargar", 16'(cargar), 16'd0);
        press(1, 0, 0, 0);
        check_eq("r030_idle_up", 16'(tiempo_establecido), 16'h000);

        // Held up on units for 10 cycles
        do_reset();
        repeat (3) press(0, 0, 1, 0);
        repeat (10) step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
`ifdef PROGRAMADOR_AUTOREPEAT_EN
        check_eq("r031_hold", 16'(tiempo_establecido), 16'h004);
`else
        check_eq("r031_hold", 16'(tiempo_establecido), 16'h001);
`endif

        // Random button traffic with long holds and occasional reset
        u = 0; dn = 0; s = 0; o = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) u = ~u;
            if ($urandom_range(0, 5) == 0) dn = ~dn;
            if ($urandom_range(0, 9) == 0) s = ~s;
            if ($urandom_range(0, 15) == 0) o = ~o;
            step(u, dn, s, o, ($urandom_range(0, 299) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/programador_tiempo.md
PROGRAMADOR_TIEMPO -- requirements
Module: programador_tiempo

Interface
REQ-001 Parameter REPEAT_DELAY, default 500: clk cycles a held up/down button must stay high before auto-repeat starts (AUTOREPEAT_EN builds only).
REQ-002 Parameter REPEAT_PERIOD, default 100: clk cycles between auto-repeat steps (AUTOREPEAT_EN builds only).
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 btn_up  input  1  increment selected digit; level, already synchronized and debounced, active-high.
REQ-006 btn_down  input  1  decrement selected digit; same conditioning as btn_up.
REQ-007 btn_sel  input  1  enter edit mode / advance digit selection.
REQ-008 btn_ok  input  1  confirm programmed time.
REQ-009 tiempo_establecido  output  12  programmed time: [11:8] minutes BCD, [7:4] tens of seconds BCD, [3:0] seconds BCD; drives the countdown timer's tiempo_establecido input.
REQ-010 digito_sel  output  2  selected digit: 2=minutes, 1=tens, 0=units.
REQ-011 editando  output  1  high while in state EDIT.
REQ-012 cargar  output  1  one-cycle pulse when a time is confirmed.

Function
REQ-013 Each button SHALL be edge-detected with a registered previous value; an action fires only on a 0->1 transition, once per press regardless of hold length (except auto-repeat, REQ-024).
REQ-014 FSM states SHALL be IDLE, EDIT and LISTO; all outputs registered.
REQ-015 IDLE: btn_sel edge -> EDIT with digito_sel=2; all other buttons ignored.
REQ-016 EDIT: btn_up edge increments the selected digit modulo its range: units and minutes 0..9 (9->0), tens 0..5 (5->0); no carry or borrow into neighbouring digits.
REQ-017 EDIT: btn_down edge decrements modulo range: units/minutes 0->9, tens 0->5; no borrow.
REQ-018 EDIT: btn_sel edge cycles digito_sel 2->1->0->2.
REQ-019 EDIT: btn_ok edge with tiempo_establecido != 0 -> LISTO and cargar=1 for exactly the next cycle; with tiempo_establecido == 0, stay in EDIT, no pulse.
REQ-020 LISTO: tiempo_establecido held; btn_up/btn_down/btn_ok ignored; btn_sel edge -> EDIT with digito_sel=2, value retained for editing.
REQ-021 Simultaneous edges in one cycle SHALL be resolved by priority ok > sel > up/down; up and down together SHALL leave the digit unchanged.
REQ-022 Digit values SHALL never leave their BCD range; tiempo_establecido changes only in EDIT.

Reset
REQ-023 reset high at a clock edge SHALL force state IDLE, tiempo_establecido=12'h000, digito_sel=2'd0, editando=0, cargar=0, edge registers=0, repeat counters=0, with priority over any button, including mid-edit or during a cargar pulse.

Configuration
REQ-024 Macro PROGRAMADOR_AUTOREPEAT_EN: when defined, in EDIT a btn_up or btn_down held high (alone) for REPEAT_DELAY cycles after its edge SHALL generate one extra step, then one step every REPEAT_PERIOD cycles while held; releasing, pressing the other button, or leaving EDIT clears the counter.
REQ-025 Without PROGRAMADOR_AUTOREPEAT_EN the repeat counters SHALL not be synthesized and a held button gives exactly one step.

Verification
REQ-026 reset; sel; up x3; ok -> digito_sel=2, tiempo_establecido=12'h300, state LISTO, cargar high exactly 1 cycle.
REQ-027 EDIT, digito_sel=1 (tens) at 5, up -> tens=0, minutes unchanged; down at 0 -> tens=5; units at 0 down -> units=9, tens unchanged.
REQ-028 EDIT with 12'h000, ok -> stays EDIT, cargar stays 0; then up on units and ok -> 12'h001, LISTO, one cargar pulse.
REQ-029 EDIT, up and down edges same cycle -> no change; ok and up same cycle with 12'h120 -> LISTO, value 12'h120 unchanged.
REQ-030 LISTO 12'h245, reset asserted one cycle -> next cycle IDLE, 12'h000, editando=0, cargar=0; btn_up alone in IDLE -> no change.
REQ-031 With PROGRAMADOR_AUTOREPEAT_EN, REPEAT_DELAY=4, REPEAT_PERIOD=2: units from 0, hold up 10 cycles -> units=4 (edge, +delay, then every 2); without macro same stimulus -> units=1.
